// File: rtl/itch_parser_wide_if.sv
// Stream-in / record-out bundle between the payload extractor, the wide ITCH parser and the order book.
interface itch_parser_wide_if #(
  parameter int unsigned BYTES_PER_BEAT = 4,
  parameter int unsigned DROP_CNT_W     = 16
);
  logic [8*BYTES_PER_BEAT-1:0] data_i;
  logic                        valid_i;
  logic                        ready_o;
  logic [31:0]                 stock_id_o;
  logic [31:0]                 order_ref_num_o;
  logic [31:0]                 num_shares_o;
  logic [31:0]                 price_o;
  logic [3:0]                  order_type_o;
  logic                        buy_sell_o;
  logic                        valid_o;
  logic                        ready_i;
  logic [DROP_CNT_W-1:0]       drop_count_o;

  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, stock_id_o, order_ref_num_o, num_shares_o, price_o,
           order_type_o, buy_sell_o, valid_o, drop_count_o
  );

  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, stock_id_o, order_ref_num_o, num_shares_o, price_o,
           order_type_o, buy_sell_o, valid_o, drop_count_o
  );
endinterface

// File: rtl/itch_parser_wide.sv
// Multi-lane ITCH parser: walks BYTES_PER_BEAT stream bytes per beat, decodes A/F/D/E/X into a record FIFO.
module itch_parser_wide #(
  parameter int unsigned BYTES_PER_BEAT = 4,
  parameter int unsigned FIFO_DEPTH     = 4,
  parameter int unsigned DROP_CNT_W     = 16
) (
  input  logic              clk,
  input  logic              reset,
  itch_parser_wide_if.slave bus
);
  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam int unsigned OFF_W = 17;

  localparam logic [1:0] S_LEN_HI = 2'd0;
  localparam logic [1:0] S_LEN_LO = 2'd1;
  localparam logic [1:0] S_BODY   = 2'd2;

  typedef struct packed {
    logic [31:0] stock;
    logic [31:0] ref_n;
    logic [31:0] shares;
    logic [31:0] price;
    logic [3:0]  otype;
    logic        bs;
  } rec_t;

  logic [1:0]            st_q, st_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic [15:0]           len_q, len_d;
  logic [7:0]            typ_q, typ_d;
  logic [31:0]           ref_q, ref_d, shares_q, shares_d, stock_q, stock_d, price_q, price_d;
  logic                  bs_q, bs_d;
  logic [DROP_CNT_W-1:0] drop_q, drop_d;
  rec_t                  mem_q [FIFO_DEPTH];
  rec_t                  mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_q, wr_d, rd_q, rd_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  ready_q, ready_d, valid_q, valid_d;

  logic       acc_c, pop_c, push_c, drop_c, is_af_c, is_ex_c;
  logic [7:0] byte_c;
  rec_t       rec_c;

  function automatic logic in_rng(logic [OFF_W-1:0] off, int unsigned lo, int unsigned hi);
    return (off >= OFF_W'(lo)) && (off <= OFF_W'(hi));
  endfunction

  assign acc_c = bus.valid_i && ready_q;
  assign pop_c = valid_q && bus.ready_i;

  // Byte-serial walk across the lanes; the running state carries lane to lane within the beat.
  always_comb begin
    st_d     = st_q;
    off_d    = off_q;
    len_d    = len_q;
    typ_d    = typ_q;
    ref_d    = ref_q;
    shares_d = shares_q;
    stock_d  = stock_q;
    price_d  = price_q;
    bs_d     = bs_q;
    byte_c   = '0;
    is_af_c  = 1'b0;
    is_ex_c  = 1'b0;
    push_c   = 1'b0;
    drop_c   = 1'b0;
    rec_c    = '0;
    if (acc_c) begin
      for (int i = 0; i < int'(BYTES_PER_BEAT); i++) begin
        byte_c = bus.data_i[8*i +: 8];
        case (st_d)
          S_LEN_HI: begin
            len_d    = {byte_c, 8'h00};
            typ_d    = '0;
            ref_d    = '0;
            shares_d = '0;
            stock_d  = '0;
            price_d  = '0;
            bs_d     = 1'b0;
            off_d    = OFF_W'(1);
            st_d     = S_LEN_LO;
          end
          S_LEN_LO: begin
            len_d = {len_d[15:8], byte_c};
            if (len_d == '0) begin
              drop_c = 1'b1;
              off_d  = '0;
              st_d   = S_LEN_HI;
            end else begin
              off_d = OFF_W'(2);
              st_d  = S_BODY;
            end
          end
          S_BODY: begin
            if (off_d == OFF_W'(2)) typ_d = byte_c;
            is_af_c = (typ_d == 8'h41) || (typ_d == 8'h46);
            is_ex_c = (typ_d == 8'h45) || (typ_d == 8'h58);
            if (in_rng(off_d, 15, 18)) ref_d = {ref_d[23:0], byte_c};
            if (is_af_c && off_d == OFF_W'(19)) bs_d = (byte_c == 8'h53);
            if ((is_af_c && in_rng(off_d, 20, 23)) || (is_ex_c && in_rng(off_d, 19, 22)))
              shares_d = {shares_d[23:0], byte_c};
            if (is_af_c && in_rng(off_d, 24, 27)) stock_d = {stock_d[23:0], byte_c};
            if (is_af_c && in_rng(off_d, 34, 37)) price_d = {price_d[23:0], byte_c};
            if (off_d == OFF_W'(len_d) + OFF_W'(1)) begin
              rec_c = '{stock: stock_d, ref_n: ref_d, shares: shares_d, price: price_d,
                        otype: 4'd0, bs: bs_d};
              case (typ_d)
                8'h41, 8'h46: rec_c.otype = 4'd1;
                8'h58:        rec_c.otype = 4'd2;
                8'h45:        rec_c.otype = 4'd4;
                8'h44:        rec_c.otype = 4'd8;
                default:      rec_c.otype = 4'd0;
              endcase
              push_c = (rec_c.otype != 4'd0);
              drop_c = !push_c;
              off_d  = '0;
              st_d   = S_LEN_HI;
            end else begin
              off_d = off_d + OFF_W'(1);
            end
          end
          default: begin
            off_d = '0;
            st_d  = S_LEN_HI;
          end
        endcase
      end
    end
  end

  // Record FIFO and the saturating drop counter.
  always_comb begin
    mem_d = mem_q;
    wr_d  = wr_q;
    rd_d  = rd_q;
    if (push_c) begin
      mem_d[wr_q] = rec_c;
      wr_d        = wr_q + PTR_W'(1);
    end
    if (pop_c) rd_d = rd_q + PTR_W'(1);
    cnt_d   = cnt_q + CNT_W'(push_c) - CNT_W'(pop_c);
    ready_d = (cnt_d < CNT_W'(FIFO_DEPTH));
    valid_d = (cnt_d != '0);
    drop_d  = drop_q;
    if (drop_c && (drop_q != '1)) drop_d = drop_q + DROP_CNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      st_q     <= S_LEN_HI;
      off_q    <= '0;
      len_q    <= '0;
      typ_q    <= '0;
      ref_q    <= '0;
      shares_q <= '0;
      stock_q  <= '0;
      price_q  <= '0;
      bs_q     <= 1'b0;
      drop_q   <= '0;
      mem_q    <= '{default: '0};
      wr_q     <= '0;
      rd_q     <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b1;
      valid_q  <= 1'b0;
    end else begin
      st_q     <= st_d;
      off_q    <= off_d;
      len_q    <= len_d;
      typ_q    <= typ_d;
      ref_q    <= ref_d;
      shares_q <= shares_d;
      stock_q  <= stock_d;
      price_q  <= price_d;
      bs_q     <= bs_d;
      drop_q   <= drop_d;
      mem_q    <= mem_d;
      wr_q     <= wr_d;
      rd_q     <= rd_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      valid_q  <= valid_d;
    end
  end

  assign bus.ready_o         = ready_q;
  assign bus.valid_o         = valid_q;
  assign bus.stock_id_o      = mem_q[rd_q].stock;
  assign bus.order_ref_num_o = mem_q[rd_q].ref_n;
  assign bus.num_shares_o    = mem_q[rd_q].shares;
  assign bus.price_o         = mem_q[rd_q].price;
  assign bus.order_type_o    = mem_q[rd_q].otype;
  assign bus.buy_sell_o      = mem_q[rd_q].bs;
  assign bus.drop_count_o    = drop_q;
endmodule
